ddr_ui_mem_responder: RTL and testbench

//  Responder side of the ddr_ram_control_mig user interface (wr_*/rd_*/busy/rd_data_valid).

---
 rtl/ddr_ui_mem_responder.sv | 118 +++++++++++
 tb/tb_ddr_ui_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr_ui_mem_responder.sv
// Behavioural stand-in for the MIG user interface: block-RAM backed store with fixed
// read latency, bounded outstanding reads and optional write-hold / refresh stalls.
module ddr_ui_mem_responder #(
   parameter int ADDR_W         = 25,
   parameter int DATA_W         = 256,
   parameter int DEPTH_LOG2     = 10,
   parameter int RD_LATENCY     = 4,
   parameter int RD_QUEUE_DEPTH = 4,
   parameter int WR_BUSY_CYCLES = 0,
   parameter int REFRESH_PERIOD = 0,
   parameter int REFRESH_LEN    = 8
) (
   input  logic              ui_clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_en,
   output logic              wr_busy,
   output logic              rd_busy,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_valid,
   output logic [31:0]       wr_count,
   output logic [31:0]       rd_count
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int OW    = $clog2(RD_QUEUE_DEPTH + 1);
   localparam int HW    = (WR_BUSY_CYCLES > 0) ? $clog2(WR_BUSY_CYCLES + 1) : 1;

   typedef enum logic {RUN, REFRESH} state_t;

   state_t                  state;
   logic [31:0]             timer;
   logic [HW-1:0]           wr_hold;
   logic [OW-1:0]           outstanding;
   logic [DATA_W-1:0]       mem [DEPTH];
   logic [RD_LATENCY:1]     vld_pipe;
   logic [DATA_W-1:0]       dat_pipe [1:RD_LATENCY];
   logic [DEPTH_LOG2-1:0]   widx, ridx;
   logic                    refresh_active, retire, wr_acc, rd_acc;

   assign widx           = wr_addr[DEPTH_LOG2-1:0];
   assign ridx           = rd_addr[DEPTH_LOG2-1:0];
   assign refresh_active = (state == REFRESH);
   assign retire         = vld_pipe[RD_LATENCY];

   // Busy depends on registered state only; retire frees a slot in the same cycle.
   assign wr_busy = refresh_active | (wr_hold != '0);
   assign rd_busy = refresh_active | ((outstanding == OW'(RD_QUEUE_DEPTH)) & ~retire);

   // Gating with rst keeps a request held during reset from touching the RAM.
   assign wr_acc = rst & wr_en & ~wr_busy;
   assign rd_acc = rst & rd_en & ~rd_busy;

   assign rd_data       = dat_pipe[RD_LATENCY];
   assign rd_data_valid = vld_pipe[RD_LATENCY];

   always_ff @(posedge ui_clk) begin
      if (wr_acc) mem[widx] <= wr_data;
   end

   always_ff @(posedge ui_clk) begin
      if (!rst) begin
         state       <= RUN;
         timer       <= '0;
         wr_hold     <= '0;
         outstanding <= '0;
         vld_pipe    <= '0;
         wr_count    <= '0;
         rd_count    <= '0;
         for (int k = 1; k <= RD_LATENCY; k++) dat_pipe[k] <= '0;
      end else begin
         vld_pipe[1] <= rd_acc;
         if (rd_acc)
            dat_pipe[1] <= (wr_acc && widx == ridx) ? wr_data : mem[ridx];
         // Data stages only advance with a valid word so rd_data holds between pulses.
         for (int k = 2; k <= RD_LATENCY; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
         end

         case ({rd_acc, retire})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase

         if (wr_acc)              wr_hold <= HW'(WR_BUSY_CYCLES);
         else if (wr_hold != '0)  wr_hold <= wr_hold - 1'b1;

         if (wr_acc) wr_count <= wr_count + 32'd1;
         if (retire) rd_count <= rd_count + 32'd1;

         case (state)
            RUN: begin
               if (REFRESH_PERIOD != 0) begin
                  if (timer == 32'(REFRESH_PERIOD - 1)) begin
                     state <= REFRESH;
                     timer <= '0;
                  end else begin
                     timer <= timer + 32'd1;
                  end
               end
            end
            REFRESH: begin
               if (timer >= 32'(REFRESH_LEN - 1)) begin
                  state <= RUN;
                  timer <= '0;
               end else begin
                  timer <= timer + 32'd1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_ddr_ui_mem_responder.sv
// Directed bench: default instance, a 2-deep read queue instance and a refresh/write-hold
// instance, all fed from the same request signals.
module tb_ddr_ui_mem_responder;
   logic         ui_clk, rst;
   logic [24:0]  wr_addr, rd_addr;
   logic [255:0] wr_data;
   logic         wr_en, rd_en;

   logic         d_wb, d_rb, d_v, q_wb, q_rb, q_v, r_wb, r_rb, r_v;
   logic [255:0] d_rd, q_rd, r_rd;
   logic [31:0]  d_wc, d_rc, q_wc, q_rc, r_wc, r_rc;

   int total = 0;
   int bad   = 0;

   ddr_ui_mem_responder u_dut (
      .ui_clk(ui_clk), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .rd_addr(rd_addr), .rd_en(rd_en), .wr_busy(d_wb), .rd_busy(d_rb), .rd_data(d_rd),
      .rd_data_valid(d_v), .wr_count(d_wc), .rd_count(d_rc));

   ddr_ui_mem_responder #(.RD_QUEUE_DEPTH(2)) u_q2 (
      .ui_clk(ui_clk), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .rd_addr(rd_addr), .rd_en(rd_en), .wr_busy(q_wb), .rd_busy(q_rb), .rd_data(q_rd),
      .rd_data_valid(q_v), .wr_count(q_wc), .rd_count(q_rc));

   ddr_ui_mem_responder #(.REFRESH_PERIOD(100), .REFRESH_LEN(8), .WR_BUSY_CYCLES(2)) u_ref (
      .ui_clk(ui_clk), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .rd_addr(rd_addr), .rd_en(rd_en), .wr_busy(r_wb), .rd_busy(r_rb), .rd_data(r_rd),
      .rd_data_valid(r_v), .wr_count(r_wc), .rd_count(r_rc));

   initial begin
      ui_clk = 0;
      forever #5 ui_clk = ~ui_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   task automatic step;
      @(posedge ui_clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 0; wr_en = 0; rd_en = 0;
      step; step;
      rst = 1;
   endtask

   task automatic do_write(input logic [24:0] a, input logic [255:0] d);
      wr_en = 1; wr_addr = a; wr_data = d;
      step;
      wr_en = 0;
   endtask

   // Returns cycles from accept cycle to valid (bounded) and the data seen then.
   task automatic wait_valid(output int lat, output logic [255:0] d);
      lat = 1;
      while (!d_v && lat < 20) begin
         step;
         lat++;
      end
      d = d_rd;
   endtask

   task automatic do_read(input logic [24:0] a, output int lat, output logic [255:0] d);
      rd_en = 1; rd_addr = a;
      step;
      rd_en = 0;
      wait_valid(lat, d);
   endtask

   task automatic test_reset;
      int lat;
      logic [255:0] d;
      do_reset;
      do_write(25'd7, 256'h77);
      rst = 0; wr_en = 1; wr_addr = 25'd7; wr_data = 256'hDEAD; rd_en = 1; rd_addr = 25'd7;
      for (int i = 0; i < 3; i++) begin
         step;
         total++; if (d_wb !== 1'b0) begin bad++; $display("FAIL reset_wr_busy got=%0b want=0", d_wb); end
         total++; if (d_rb !== 1'b0) begin bad++; $display("FAIL reset_rd_busy got=%0b want=0", d_rb); end
         total++; if (d_v !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", d_v); end
         total++; if (d_rd !== 256'h0) begin bad++; $display("FAIL reset_rd_data got=%0h want=0", d_rd); end
         total++; if (d_wc !== 32'h0) begin bad++; $display("FAIL reset_wr_count got=%0d want=0", d_wc); end
         total++; if (d_rc !== 32'h0) begin bad++; $display("FAIL reset_rd_count got=%0d want=0", d_rc); end
      end
      rst = 1; wr_en = 0; rd_en = 0;
      for (int i = 0; i < 5; i++) begin
         step;
         total++; if (d_v !== 1'b0) begin bad++; $display("FAIL reset_post_valid got=%0b want=0", d_v); end
      end
      do_read(25'd7, lat, d);
      total++; if (d !== 256'h77) begin bad++; $display("FAIL reset_no_ram_write got=%0h want=77", d); end
      total++; if (d_wc !== 32'd0) begin bad++; $display("FAIL reset_wr_count_after got=%0d want=0", d_wc); end
   endtask

   task automatic test_write_read;
      int lat;
      logic [255:0] d;
      do_reset;
      do_write(25'd5, 256'hA5);
      total++; if (d_wc !== 32'd1) begin bad++; $display("FAIL wr_count got=%0d want=1", d_wc); end
      step;
      do_read(25'd5, lat, d);
      total++; if (lat !== 4) begin bad++; $display("FAIL read_latency got=%0d want=4", lat); end
      total++; if (d !== 256'hA5) begin bad++; $display("FAIL read_data got=%0h want=a5", d); end
      step;
      total++; if (d_v !== 1'b0) begin bad++; $display("FAIL valid_pulse got=%0b want=0", d_v); end
      total++; if (d_rd !== 256'hA5) begin bad++; $display("FAIL rd_data_hold got=%0h want=a5", d_rd); end
      total++; if (d_rc !== 32'd1) begin bad++; $display("FAIL rd_count got=%0d want=1", d_rc); end
   endtask

   task automatic test_back_to_back;
      int got = 0, g2 = 0, first = -1, last = -1, exp_a;
      for (int i = 0; i < 16; i++) do_write(25'(i), 256'h100 + 256'(i));
      for (int t = 0; t < 40; t++) begin
         if (t < 16) begin
            total++; if (d_rb !== 1'b0) begin bad++; $display("FAIL full_rate_busy t=%0d got=%0b want=0", t, d_rb); end
            total++; if (q_rb !== ((t % 4) >= 2)) begin bad++; $display("FAIL q2_busy t=%0d got=%0b want=%0b", t, q_rb, (t % 4) >= 2); end
         end
         if (d_v) begin
            total++; if (d_rd !== 256'h100 + 256'(got)) begin bad++; $display("FAIL full_rate_data n=%0d got=%0h want=%0h", got, d_rd, 256'h100 + 256'(got)); end
            if (got == 0) first = t;
            last = t;
            got++;
         end
         if (q_v) begin
            exp_a = (g2 / 2) * 4 + (g2 % 2);
            total++; if (q_rd !== 256'h100 + 256'(exp_a)) begin bad++; $display("FAIL q2_data n=%0d got=%0h want=%0h", g2, q_rd, 256'h100 + 256'(exp_a)); end
            g2++;
         end
         rd_en = (t < 16); rd_addr = 25'(t);
         step;
      end
      rd_en = 0;
      total++; if (got !== 16) begin bad++; $display("FAIL full_rate_count got=%0d want=16", got); end
      total++; if (first !== 4) begin bad++; $display("FAIL full_rate_first got=%0d want=4", first); end
      total++; if (last !== 19) begin bad++; $display("FAIL full_rate_last got=%0d want=19", last); end
      total++; if (g2 !== 8) begin bad++; $display("FAIL q2_count got=%0d want=8", g2); end
   endtask

   task automatic test_bypass;
      int lat;
      logic [255:0] d;
      wr_en = 1; wr_addr = 25'h403; wr_data = 256'h1; rd_en = 1; rd_addr = 25'd3;
      step;
      wr_en = 0; rd_en = 0;
      wait_valid(lat, d);
      total++; if (lat !== 4) begin bad++; $display("FAIL bypass_latency got=%0d want=4", lat); end
      total++; if (d !== 256'h1) begin bad++; $display("FAIL bypass_data got=%0h want=1", d); end
      step;
      do_read(25'd3, lat, d);
      total++; if (d !== 256'h1) begin bad++; $display("FAIL alias_data got=%0h want=1", d); end
   endtask

   task automatic test_refresh;
      logic rf;
      do_reset;
      for (int c = 0; c < 116; c++) begin
         rf = (c >= 100 && c <= 107);
         total++; if (r_rb !== rf) begin bad++; $display("FAIL refresh_rd_busy c=%0d got=%0b want=%0b", c, r_rb, rf); end
         total++; if (r_wb !== (rf || c == 1 || c == 2)) begin bad++; $display("FAIL refresh_wr_busy c=%0d got=%0b want=%0b", c, r_wb, rf || c == 1 || c == 2); end
         total++; if (r_v !== (c == 102)) begin bad++; $display("FAIL refresh_valid c=%0d got=%0b want=%0b", c, r_v, c == 102); end
         if (c == 102) begin
            total++; if (r_rd !== 256'h99) begin bad++; $display("FAIL refresh_data got=%0h want=99", r_rd); end
         end
         wr_en = (c == 0); wr_addr = 25'd9; wr_data = 256'h99;
         rd_en = (c == 98 || c == 100); rd_addr = 25'd9;
         step;
      end
      wr_en = 0; rd_en = 0;
      total++; if (r_rc !== 32'd1) begin bad++; $display("FAIL refresh_rd_count got=%0d want=1", r_rc); end
   endtask

   task automatic test_reset_inflight;
      int lat;
      logic [255:0] d;
      rd_en = 1; rd_addr = 25'd5; step;
      rd_addr = 25'd6; step;
      rd_addr = 25'd7; step;
      rst = 0; rd_en = 0;
      step;
      rst = 1;
      total++; if (q_rb !== 1'b0) begin bad++; $display("FAIL inflight_q2_busy got=%0b want=0", q_rb); end
      total++; if (d_rd !== 256'h0) begin bad++; $display("FAIL inflight_rd_data got=%0h want=0", d_rd); end
      for (int i = 0; i < 8; i++) begin
         total++; if (d_v !== 1'b0) begin bad++; $display("FAIL inflight_valid i=%0d got=%0b want=0", i, d_v); end
         total++; if (q_v !== 1'b0) begin bad++; $display("FAIL inflight_q2_valid i=%0d got=%0b want=0", i, q_v); end
         step;
      end
      total++; if (d_rc !== 32'd0) begin bad++; $display("FAIL inflight_rd_count got=%0d want=0", d_rc); end
      do_read(25'd5, lat, d);
      total++; if (lat !== 4) begin bad++; $display("FAIL inflight_next_latency got=%0d want=4", lat); end
      total++; if (d !== 256'h105) begin bad++; $display("FAIL inflight_next_data got=%0h want=105", d); end
      step;
      total++; if (d_rc !== 32'd1) begin bad++; $display("FAIL inflight_next_count got=%0d want=1", d_rc); end
   endtask

   initial begin
      rst = 0; wr_en = 0; rd_en = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
      test_reset;
      test_write_read;
      test_back_to_back;
      test_bypass;
      test_refresh;
      test_reset_inflight;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
